// File: rtl/cache_request_scheduler_if.sv
// Bundle of requester-side and cache-side signals for cache_request_scheduler.
// The scheduler takes the slave view; requesters, cache and control drive the master view.
interface cache_request_scheduler_if #(
   parameter int unsigned NUM_MEMORY_REQUESTOR      = 2,
   parameter int unsigned ADDR_WIDTH                = 64,
   parameter int unsigned DATA_WIDTH                = 512,
   parameter int unsigned OUTSTANDING_COUNTER_MAX   = 16,
   parameter int unsigned OUTSTANDING_COUNTER_WIDTH = $clog2(OUTSTANDING_COUNTER_MAX + 1)
);
   logic [NUM_MEMORY_REQUESTOR-1:0]            req_valid_in;
   logic [NUM_MEMORY_REQUESTOR*ADDR_WIDTH-1:0] req_addr_in;
   logic [NUM_MEMORY_REQUESTOR-1:0]            req_ready_out;
   logic                                       cache_req_valid_out;
   logic [ADDR_WIDTH-1:0]                      cache_req_addr_out;
   logic                                       cache_req_ready_in;
   logic                                       cache_resp_valid_in;
   logic [DATA_WIDTH-1:0]                      cache_resp_data_in;
   logic [NUM_MEMORY_REQUESTOR-1:0]            resp_valid_out;
   logic [DATA_WIDTH-1:0]                      resp_data_out;
   logic                                       drain_in;
   logic                                       drain_done_out;
   logic [OUTSTANDING_COUNTER_WIDTH-1:0]       outstanding_count_out;
   logic                                       resp_underflow_out;

   modport slave (
      input  req_valid_in, req_addr_in, cache_req_ready_in, cache_resp_valid_in,
             cache_resp_data_in, drain_in,
      output req_ready_out, cache_req_valid_out, cache_req_addr_out, resp_valid_out,
             resp_data_out, drain_done_out, outstanding_count_out, resp_underflow_out
   );

   modport master (
      output req_valid_in, req_addr_in, cache_req_ready_in, cache_resp_valid_in,
             cache_resp_data_in, drain_in,
      input  req_ready_out, cache_req_valid_out, cache_req_addr_out, resp_valid_out,
             resp_data_out, drain_done_out, outstanding_count_out, resp_underflow_out
   );
endinterface

// File: rtl/cache_request_scheduler.sv
// Round-robin arbiter sharing one cache request port, with a credit limit, an in-order
// ID queue routing responses back to their requester, and drain/quiesce control.
module cache_request_scheduler #(
   parameter int unsigned NUM_MEMORY_REQUESTOR      = 2,
   parameter int unsigned ADDR_WIDTH                = 64,
   parameter int unsigned DATA_WIDTH                = 512,
   parameter int unsigned OUTSTANDING_COUNTER_MAX   = 16,
   parameter int unsigned OUTSTANDING_COUNTER_WIDTH = $clog2(OUTSTANDING_COUNTER_MAX + 1)
) (
   input logic                    ap_clk,
   input logic                    areset,
   cache_request_scheduler_if.slave bus
);
   localparam int unsigned N   = NUM_MEMORY_REQUESTOR;
   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned CIW = IDW + 1;
   localparam int unsigned MAX = OUTSTANDING_COUNTER_MAX;
   localparam int unsigned QAW = (MAX > 1) ? $clog2(MAX) : 1;
   localparam int unsigned CW  = OUTSTANDING_COUNTER_WIDTH;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

   state_e                  state_q, state_d;
   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [IDW-1:0]          idq_q [MAX];
   logic [QAW-1:0]          wr_q, wr_d, rd_q, rd_d;
   logic                    creq_valid_q, creq_valid_d;
   logic [ADDR_WIDTH-1:0]   creq_addr_q, creq_addr_d;
   logic [N-1:0]            resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    underflow_q, underflow_d;
   logic                    done_q;
   logic                    grant, pop;
   logic [IDW-1:0]          gnt_idx;
   logic [CIW-1:0]          cand;
   logic [N-1:0]            req_ready;

   function automatic logic [QAW-1:0] qnext(input logic [QAW-1:0] p);
      return (p == QAW'(MAX - 1)) ? '0 : p + 1'b1;
   endfunction

   // ptr_q holds the highest-priority index, i.e. one past the last grant.
   always_comb begin
      grant   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (!areset && state_q == RUN && !bus.drain_in && count_q < CW'(MAX) &&
          (!creq_valid_q || bus.cache_req_ready_in)) begin
         for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + CIW'(k);
            if (cand >= CIW'(N)) cand = cand - CIW'(N);
            if (!grant && bus.req_valid_in[cand[IDW-1:0]]) begin
               grant   = 1'b1;
               gnt_idx = cand[IDW-1:0];
            end
         end
      end
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      pop          = bus.cache_resp_valid_in && (count_q != '0);
      ptr_d        = ptr_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      creq_valid_d = creq_valid_q;
      creq_addr_d  = creq_addr_q;
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      underflow_d  = underflow_q | (bus.cache_resp_valid_in && (count_q == '0));
      count_d      = count_q + CW'(grant) - CW'(pop);
      if (grant) begin
         ptr_d        = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
         wr_d         = qnext(wr_q);
         creq_valid_d = 1'b1;
         creq_addr_d  = bus.req_addr_in[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end else if (bus.cache_req_ready_in) begin
         creq_valid_d = 1'b0;
      end
      if (pop) begin
         rd_d                      = qnext(rd_q);
         resp_valid_d[idq_q[rd_q]] = 1'b1;
         resp_data_d               = bus.cache_resp_data_in;
      end
      // DONE is judged on next-cycle values so drain_done rises with the last response.
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.drain_in) state_d = DRAIN;
         DRAIN:   if (!bus.drain_in) state_d = RUN;
                  else if (!creq_valid_d && count_d == '0) state_d = DONE;
         DONE:    if (!bus.drain_in) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (grant) idq_q[wr_q] <= gnt_idx;
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state_q      <= RUN;
         ptr_q        <= '0;
         count_q      <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         creq_valid_q <= 1'b0;
         creq_addr_q  <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         underflow_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         creq_valid_q <= creq_valid_d;
         creq_addr_q  <= creq_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         underflow_q  <= underflow_d;
         done_q       <= (state_d == DONE);
      end
   end

   assign bus.req_ready_out         = req_ready;
   assign bus.cache_req_valid_out   = creq_valid_q;
   assign bus.cache_req_addr_out    = creq_addr_q;
   assign bus.resp_valid_out        = resp_valid_q;
   assign bus.resp_data_out         = resp_data_q;
   assign bus.drain_done_out        = done_q;
   assign bus.outstanding_count_out = count_q;
   assign bus.resp_underflow_out    = underflow_q;
endmodule

// File: tb/tb_cache_request_scheduler.sv
// Bench for cache_request_scheduler: queue-based reference model checked every cycle,
// a directed vector table, hand-written corner sequences and a randomized run.
module tb_cache_request_scheduler;
   localparam int unsigned N   = 2;
   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 512;
   localparam int unsigned MAX = 16;
   localparam int unsigned CW  = 5;

   logic ap_clk = 1'b0;
   logic areset;
   always #5 ap_clk = ~ap_clk;

   cache_request_scheduler_if #(
      .NUM_MEMORY_REQUESTOR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .OUTSTANDING_COUNTER_MAX(MAX), .OUTSTANDING_COUNTER_WIDTH(CW)
   ) bif ();

   cache_request_scheduler #(
      .NUM_MEMORY_REQUESTOR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .OUTSTANDING_COUNTER_MAX(MAX), .OUTSTANDING_COUNTER_WIDTH(CW)
   ) dut (
      .ap_clk (ap_clk),
      .areset (areset),
      .bus    (bif)
   );

   int tests = 0;
   int fails = 0;

   // reference model: requester IDs awaiting responses, in issue order
   int              q_ids[$];
   int              m_ptr;
   bit              m_cv;
   logic [AW-1:0]   m_ca;
   logic [N-1:0]    m_rv;
   logic [DW-1:0]   m_rd;
   bit              m_uf;
   int              m_mode;   // 0 running, 1 draining, 2 drained
   // values sampled from the DUT each cycle
   logic [N-1:0]    s_ready, s_rv;
   logic            s_cv, s_done, s_uf;
   logic [AW-1:0]   s_ca;
   logic [DW-1:0]   s_rd;
   logic [CW-1:0]   s_cnt;

   typedef struct {
      logic [N-1:0] valid;
      logic         rdy;
      logic         resp;
      logic         drain;
      logic [N-1:0] exp_ready;
      int           exp_cnt;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q_ids.delete();
      m_ptr = 0; m_cv = 0; m_ca = '0; m_rv = '0; m_rd = '0; m_uf = 0; m_mode = 0;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // One clock: sample and compare at the falling edge, advance the model, return at posedge+1.
   task automatic tick();
      logic [N-1:0] exp_ready;
      int g, h;
      @(negedge ap_clk);
      s_ready = bif.req_ready_out;  s_cv  = bif.cache_req_valid_out;
      s_ca    = bif.cache_req_addr_out; s_rv = bif.resp_valid_out;
      s_rd    = bif.resp_data_out;  s_done = bif.drain_done_out;
      s_cnt   = bif.outstanding_count_out; s_uf = bif.resp_underflow_out;
      g = -1;
      if (!areset && m_mode == 0 && !bif.drain_in && q_ids.size() < int'(MAX) &&
          (!m_cv || bif.cache_req_ready_in))
         for (int k = 0; k < int'(N); k++) begin
            int c = (m_ptr + k) % int'(N);
            if (g < 0 && bif.req_valid_in[c]) g = c;
         end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", s_ready, exp_ready);
      check("cache_req_valid", s_cv, m_cv);
      if (m_cv) check("cache_req_addr", s_ca, m_ca);
      check("resp_valid", s_rv, m_rv);
      if (m_rv != '0) check("resp_data", s_rd, m_rd);
      check("drain_done", s_done, m_mode == 2);
      check("count", s_cnt, q_ids.size());
      check("underflow", s_uf, m_uf);
      if (areset) model_reset();
      else begin
         m_rv = '0;
         if (bif.cache_resp_valid_in) begin
            if (q_ids.size() > 0) begin
               h = q_ids.pop_front();
               m_rv[h] = 1'b1;
               m_rd = bif.cache_resp_data_in;
            end else m_uf = 1;
         end
         if (g >= 0) begin
            m_cv = 1; m_ca = bif.req_addr_in[g*AW +: AW];
            q_ids.push_back(g); m_ptr = (g + 1) % int'(N);
         end else if (bif.cache_req_ready_in) m_cv = 0;
         if (!bif.drain_in) m_mode = 0;
         else if (m_mode == 0) m_mode = 1;
         else if (!m_cv && q_ids.size() == 0) m_mode = 2;
      end
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_in(input logic [N-1:0] v, input logic rdy, input logic resp, input logic drn);
      bif.req_valid_in = v; bif.cache_req_ready_in = rdy;
      bif.cache_resp_valid_in = resp; bif.drain_in = drn;
      bif.cache_resp_data_in = rand_data();
   endtask

   task automatic do_reset();
      set_in('0, 1'b1, 1'b0, 1'b0);
      areset = 1'b1;
      tick();
      areset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] d0, d1, d2;
      int tally;
      tbl[0] = '{2'b11, 1, 0, 0, 2'b01, 0};
      tbl[1] = '{2'b11, 1, 0, 0, 2'b10, 1};
      tbl[2] = '{2'b11, 1, 0, 0, 2'b01, 2};
      tbl[3] = '{2'b11, 0, 0, 0, 2'b00, 3};
      tbl[4] = '{2'b11, 1, 1, 0, 2'b10, 3};
      tbl[5] = '{2'b00, 1, 1, 0, 2'b00, 3};
      tbl[6] = '{2'b01, 1, 0, 0, 2'b01, 2};
      tbl[7] = '{2'b10, 1, 0, 1, 2'b00, 3};

      bif.req_addr_in = {64'h0000_0000_0000_0200, 64'h0000_0000_0000_0100};
      set_in('0, 1'b1, 1'b0, 1'b0);
      areset = 1'b1;
      repeat (2) @(posedge ap_clk);
      #1;
      areset = 1'b0;
      model_reset();
      tick();
      check("reset_count", s_cnt, 0);
      check("reset_cvalid", s_cv, 0);
      check("reset_done", s_done, 0);

      // directed table: alternation, stall, same-cycle grant+response, drain blocks grant
      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i].valid, tbl[i].rdy, tbl[i].resp, tbl[i].drain);
         tick();
         check("tbl_ready", s_ready, tbl[i].exp_ready);
         check("tbl_count", s_cnt, tbl[i].exp_cnt);
      end

      // credit limit
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 1'b0);
      tally = 0;
      repeat (20) begin tick(); tally += int'(s_ready[0]); end
      check("credit_grants", tally, 16);
      check("credit_count", s_cnt, 16);
      check("credit_ready", s_ready, 2'b00);
      set_in(2'b01, 1'b1, 1'b1, 1'b0);
      tick();
      check("credit_full_ready", s_ready, 2'b00);
      set_in(2'b01, 1'b1, 1'b0, 1'b0);
      tick();
      check("credit_15", s_cnt, 15);
      check("credit_regrant", s_ready, 2'b01);
      tick();
      check("credit_16", s_cnt, 16);
      check("credit_ready2", s_ready, 2'b00);

      // output stall
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (5) begin
         tick();
         check("stall_ready", s_ready, 2'b00);
         check("stall_valid", s_cv, 1'b1);
         check("stall_addr", s_ca, 64'h100);
      end
      set_in(2'b11, 1'b1, 1'b0, 1'b0);
      tick();
      check("stall_release", s_ready, 2'b10);

      // response routing for issue order 1,0,1
      do_reset();
      set_in(2'b10, 1'b1, 1'b0, 1'b0); tick();
      set_in(2'b01, 1'b1, 1'b0, 1'b0); tick();
      set_in(2'b10, 1'b1, 1'b0, 1'b0); tick();
      set_in(2'b00, 1'b1, 1'b1, 1'b0); d0 = bif.cache_resp_data_in; tick();
      set_in(2'b00, 1'b1, 1'b1, 1'b0); d1 = bif.cache_resp_data_in; tick();
      check("route0", s_rv, 2'b10); check("route0_data", s_rd, d0);
      set_in(2'b00, 1'b1, 1'b1, 1'b0); d2 = bif.cache_resp_data_in; tick();
      check("route1", s_rv, 2'b01); check("route1_data", s_rd, d1);
      set_in(2'b00, 1'b1, 1'b0, 1'b0); tick();
      check("route2", s_rv, 2'b10); check("route2_data", s_rd, d2);
      check("route_count", s_cnt, 0);

      // drain with three outstanding
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      set_in(2'b11, 1'b1, 1'b0, 1'b1); tick();
      check("drain_nogrant", s_ready, 2'b00);
      repeat (3) begin
         set_in(2'b11, 1'b1, 1'b1, 1'b1); tick();
         check("drain_resp_nogrant", s_ready, 2'b00);
         check("drain_not_done", s_done, 1'b0);
      end
      set_in(2'b11, 1'b1, 1'b0, 1'b1); tick();
      check("drain_done", s_done, 1'b1);
      set_in(2'b01, 1'b1, 1'b0, 1'b0); tick();
      check("drain_done_hold", s_done, 1'b1);
      tick();
      check("drain_resume", s_ready, 2'b01);
      check("drain_cleared", s_done, 1'b0);

      // underflow
      do_reset();
      set_in(2'b00, 1'b1, 1'b1, 1'b0); tick();
      set_in(2'b00, 1'b1, 1'b0, 1'b0); tick();
      check("uf_set", s_uf, 1'b1);
      check("uf_no_resp", s_rv, 2'b00);
      tick();
      check("uf_sticky", s_uf, 1'b1);
      do_reset();
      tick();
      check("uf_cleared", s_uf, 1'b0);

      // randomized run against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic drn;
         int resp_pct;
         drn = bif.drain_in;
         if ($urandom_range(99) < 3) drn = ~drn;
         resp_pct = ((i / 400) % 2 == 0) ? 25 : 70;
         bif.req_addr_in = {$urandom, $urandom, $urandom, $urandom};
         set_in(N'($urandom), $urandom_range(3) != 0, $urandom_range(99) < resp_pct, drn);
         areset = ($urandom_range(999) < 3);
         tick();
      end
      areset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
